lattice_stream_ctrl: RTL and testbench

Lattice sequencer that drives the combinational collision compute unit. For every cell it gathers the 9 post-collision distributions from the source lattice buffer (pull streaming, periodic wrap), presents them to the compute unit, captures the 9 equilibrium outputs and speed², and writes them back.
- Results go to the opposite half of a ping-pong lattice memory.
- One `start` equals one full LBM time step over the grid.

---
 rtl/lbm_pkg.sv | 32 +++
 rtl/lbm_nbr_addr.sv | 34 +++
 rtl/lattice_stream_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_lattice_stream_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lbm_pkg.sv
// Shared constants for the D2Q9 lattice sequencer: direction indices,
// velocity lookup tables, word width and controller state encoding.
package lbm_pkg;

  localparam int unsigned W  = 16;
  localparam int unsigned ND = 9;

  localparam logic [3:0] D_C  = 4'd0;
  localparam logic [3:0] D_L  = 4'd1;
  localparam logic [3:0] D_R  = 4'd2;
  localparam logic [3:0] D_T  = 4'd3;
  localparam logic [3:0] D_B  = 4'd4;
  localparam logic [3:0] D_TL = 4'd5;
  localparam logic [3:0] D_TR = 4'd6;
  localparam logic [3:0] D_BL = 4'd7;
  localparam logic [3:0] D_BR = 4'd8;

  localparam logic signed [1:0] CX [ND] = '{2'sd0, 2'sd1, -2'sd1, 2'sd0, 2'sd0,
                                            -2'sd1, 2'sd1, 2'sd1, -2'sd1};
  localparam logic signed [1:0] CY [ND] = '{2'sd0, 2'sd0, 2'sd0, -2'sd1, 2'sd1,
                                            -2'sd1, 2'sd1, -2'sd1, 2'sd1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPT,
    S_COLL,
    S_WRITE,
    S_DONE
  } state_e;

endpackage

// File: rtl/lbm_nbr_addr.sv
// Pull-streaming source address: the cell upstream of direction d,
// with periodic wrap from modulo-2^L subtraction.
module lbm_nbr_addr
  import lbm_pkg::*;
#(
  parameter int unsigned LX = 4,
  parameter int unsigned LY = 4
) (
  input  logic [LX-1:0]       x,
  input  logic [LY-1:0]       y,
  input  logic [3:0]          d,
  input  logic                parity,
  output logic [LX+LY+4:0]    addr_c
);

  logic signed [1:0] cx;
  logic signed [1:0] cy;
  logic [LX-1:0]     xs;
  logic [LY-1:0]     ys;

  always_comb begin
    cx = 2'sd0;
    cy = 2'sd0;
    if (d < 4'(ND)) begin
      cx = CX[d];
      cy = CY[d];
    end
    // signed casts sign-extend the unit step before the wrapping subtract
    xs     = x - LX'(cx);
    ys     = y - LY'(cy);
    addr_c = {parity, d, ys, xs};
  end

endmodule

// File: rtl/lattice_stream_ctrl.sv
// Per-cell gather / collide / scatter sequencer over a ping-pong lattice
// memory; one start performs one full time step (20 cycles per cell).
module lattice_stream_ctrl
  import lbm_pkg::*;
#(
  parameter int unsigned LX = 4,
  parameter int unsigned LY = 4,
  parameter int unsigned AW = 1 + 4 + LX + LY
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                parity,
  output logic                rd_en,
  output logic [AW-1:0]       rd_addr,
  input  logic [W-1:0]        rd_data,
  output logic                wr_en,
  output logic [AW-1:0]       wr_addr,
  output logic [W-1:0]        wr_data,
  output logic [9*W-1:0]      cu_f_in,
  input  logic [9*W-1:0]      cu_f_out,
  input  logic [W-1:0]        cu_uu,
  output logic                vis_we,
  output logic [LX+LY-1:0]    vis_addr,
  output logic [W-1:0]        vis_data
);

  state_e               state_q, state_d;
  logic [LX-1:0]        x_q, x_d;
  logic [LY-1:0]        y_q, y_d;
  logic [3:0]           d_q, d_d;
  logic [8:0][W-1:0]    fin_q, fin_d;
  logic [8:0][W-1:0]    fout_q, fout_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 parity_q, parity_d;
  logic                 rd_en_q, rd_en_d;
  logic [AW-1:0]        rd_addr_q, rd_addr_d;
  logic                 wr_en_q, wr_en_d;
  logic [AW-1:0]        wr_addr_q, wr_addr_d;
  logic [W-1:0]         wr_data_q, wr_data_d;
  logic                 vis_we_q, vis_we_d;
  logic [LX+LY-1:0]     vis_addr_q, vis_addr_d;
  logic [W-1:0]         vis_data_q, vis_data_d;
  logic                 last_cell;
  logic [AW-1:0]        pull_addr_c;

  lbm_nbr_addr #(.LX(LX), .LY(LY)) u_nbr_addr (
    .x      (x_d),
    .y      (y_d),
    .d      (d_d),
    .parity (parity_q),
    .addr_c (pull_addr_c)
  );

  // Next-state, cell/direction counters and data capture
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    d_d        = d_q;
    fin_d      = fin_q;
    fout_d     = fout_q;
    vis_we_d   = 1'b0;
    vis_addr_d = vis_addr_q;
    vis_data_d = vis_data_q;
    last_cell  = (x_q == {LX{1'b1}}) && (y_q == {LY{1'b1}});
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          x_d     = '0;
          y_d     = '0;
          d_d     = '0;
        end
      end
      S_FETCH: begin
        if (d_q != 4'd0) fin_d[d_q - 4'd1] = rd_data;
        if (d_q == 4'd8) state_d = S_CAPT;
        else             d_d     = d_q + 4'd1;
      end
      S_CAPT: begin
        fin_d[8] = rd_data;
        state_d  = S_COLL;
      end
      S_COLL: begin
        fout_d     = cu_f_out;
        vis_we_d   = 1'b1;
        vis_addr_d = {y_q, x_q};
        vis_data_d = cu_uu;
        d_d        = '0;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (d_q == 4'd8) begin
          d_d = '0;
          if (last_cell) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            x_d     = x_q + LX'(1);
            if (x_q == {LX{1'b1}}) y_d = y_q + LY'(1);
          end
        end else begin
          d_d = d_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered strobes and addresses, decoded from the upcoming state
  always_comb begin
    busy_d    = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d    = (state_d == S_DONE);
    parity_d  = parity_q ^ done_d;
    rd_en_d   = (state_d == S_FETCH);
    rd_addr_d = rd_en_d ? pull_addr_c : '0;
    wr_en_d   = (state_d == S_WRITE);
    wr_addr_d = wr_en_d ? {~parity_q, d_d, y_d, x_d} : '0;
    wr_data_d = wr_en_d ? fout_d[d_d] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      d_q        <= '0;
      fin_q      <= '0;
      fout_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      parity_q   <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      vis_we_q   <= 1'b0;
      vis_addr_q <= '0;
      vis_data_q <= '0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      d_q        <= d_d;
      fin_q      <= fin_d;
      fout_q     <= fout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      parity_q   <= parity_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      vis_we_q   <= vis_we_d;
      vis_addr_q <= vis_addr_d;
      vis_data_q <= vis_data_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign parity   = parity_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign cu_f_in  = fin_q;
  assign vis_we   = vis_we_q;
  assign vis_addr = vis_addr_q;
  assign vis_data = vis_data_q;

endmodule

// File: tb/tb_lattice_stream_ctrl.sv
// Directed bench for lattice_stream_ctrl on a 4x4 grid with a memory model
// and a loop-back compute stub (cu_uu = f0 + 0x122E).
module tb_lattice_stream_ctrl;

  localparam int LX = 2;
  localparam int LY = 2;
  localparam int AW = 1 + 4 + LX + LY;
  localparam int DW = 16;

  logic            clk;
  logic            reset;
  logic            start;
  logic            busy, done, parity;
  logic            rd_en, wr_en;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [DW-1:0]   rd_data, wr_data;
  logic [9*DW-1:0] cu_f_in, cu_f_out;
  logic [DW-1:0]   cu_uu;
  logic            vis_we;
  logic [LX+LY-1:0] vis_addr;
  logic [DW-1:0]   vis_data;

  logic            tb_we;
  logic [AW-1:0]   tb_addr;
  logic [DW-1:0]   tb_data;
  logic [DW-1:0]   mem [512];

  int checks;
  int errors;

  // run_step observations
  int            first_rd, first_wr, done_cyc, done_cnt, overlap;
  int            vis_cnt, vis6_cnt, vis_bad;
  logic [AW-1:0] first_rd_addr, first_wr_addr;
  logic [DW-1:0] first_wr_data, vis6_data;
  logic          busy_at1, busy_at_done, parity_after;

  int cxt [9] = '{0, 1, -1, 0, 0, -1, 1, 1, -1};
  int cyt [9] = '{0, 0, 0, -1, 1, -1, 1, -1, 1};

  lattice_stream_ctrl #(.LX(LX), .LY(LY), .AW(AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .parity   (parity),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cu_f_in  (cu_f_in),
    .cu_f_out (cu_f_out),
    .cu_uu    (cu_uu),
    .vis_we   (vis_we),
    .vis_addr (vis_addr),
    .vis_data (vis_data)
  );

  assign cu_f_out = cu_f_in;
  assign cu_uu    = cu_f_in[DW-1:0] + 16'h122E;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (tb_we)      mem[tb_addr] <= tb_data;
    else if (wr_en) mem[wr_addr] <= wr_data;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // source value of plane d at (x,y) after n streaming steps of the 16*d+cell pattern
  function automatic logic [DW-1:0] exp_val(int d, int x, int y, int n);
    int sx, sy;
    sx = (x - n * cxt[d]) & 3;
    sy = (y - n * cyt[d]) & 3;
    return 16'(16 * d + sy * 4 + sx);
  endfunction

  function automatic int addr_of(int b, int d, int x, int y);
    return b * 256 + d * 16 + y * 4 + x;
  endfunction

  task automatic fill_init();
    for (int a = 0; a < 512; a++) begin
      @(negedge clk);
      tb_we   = 1'b1;
      tb_addr = 9'(a);
      if ((a / 256) == 0 && ((a / 16) % 16) < 9) tb_data = 16'(16 * ((a / 16) % 16) + (a % 16));
      else                                        tb_data = 16'hFFFF;
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // caller must be at a negedge; ends at the negedge of the cycle after done
  task automatic run_step(input int pa, input int pb);
    first_rd = -1; first_wr = -1; done_cyc = -1; done_cnt = 0; overlap = 0;
    vis_cnt = 0; vis6_cnt = 0; vis_bad = 0; vis6_data = '0;
    first_rd_addr = '0; first_wr_addr = '0; first_wr_data = '0;
    busy_at1 = 1'b0; busy_at_done = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (k == 1) busy_at1 = busy;
      if (rd_en && first_rd < 0) begin first_rd = k; first_rd_addr = rd_addr; end
      if (wr_en && first_wr < 0) begin first_wr = k; first_wr_addr = wr_addr; first_wr_data = wr_data; end
      if (rd_en && wr_en) overlap++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = k; busy_at_done = busy; end
      end
      if (vis_we) begin
        vis_cnt++;
        if (vis_data !== 16'h122E + 16'(vis_addr)) vis_bad++;
        if (vis_addr == 4'd6) begin vis6_cnt++; vis6_data = vis_data; end
      end
      start = (k == pa || k == pb);
      if (done_cyc > 0 && k == done_cyc + 1) break;
    end
    start = 1'b0;
    parity_after = parity;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; tb_we = 1'b0; tb_addr = '0; tb_data = '0;
    #12;
    checks++; if ({rd_en, wr_en, vis_we} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {rd_en, wr_en, vis_we}); end
    checks++; if ({busy, done, parity} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b expected 000", {busy, done, parity}); end
    checks++; if ((rd_addr | wr_addr) !== '0) begin errors++; $display("FAIL reset_addr: got rd %h wr %h expected 0", rd_addr, wr_addr); end
    checks++; if (cu_f_in !== '0) begin errors++; $display("FAIL reset_cu_f_in: got %h expected 0", cu_f_in); end
    checks++; if ({wr_data, vis_data, 12'(vis_addr)} !== 44'h0) begin errors++; $display("FAIL reset_data: got wr %h vis %h/%h expected 0", wr_data, vis_data, vis_addr); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    bit found;
    fill_init();
    found = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (wr_en && wr_addr[3:0] == 4'd3) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++; $display("FAIL abort_reach_cell3: got no write of cell 3 expected one"); end
    reset = 1'b0;
    #1;
    checks++; if ({busy, wr_en, rd_en, vis_we, done} !== 5'b0) begin errors++; $display("FAIL abort_strobes: got %b expected 00000", {busy, wr_en, rd_en, vis_we, done}); end
    checks++; if (parity !== 1'b0) begin errors++; $display("FAIL abort_parity: got %b expected 0", parity); end
    checks++; if (wr_addr !== '0 || cu_f_in !== '0) begin errors++; $display("FAIL abort_clear: got wr_addr %h cu_f_in %h expected 0", wr_addr, cu_f_in); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b expected 0", busy); end
  endtask

  task automatic test_timing();
    fill_init();
    run_step(0, 0);
    checks++; if (first_rd != 1) begin errors++; $display("FAIL first_rd_cycle: got %0d expected 1", first_rd); end
    checks++; if (first_rd_addr !== 9'h000) begin errors++; $display("FAIL first_rd_addr: got %h expected 000", first_rd_addr); end
    checks++; if (busy_at1 !== 1'b1) begin errors++; $display("FAIL busy_cycle1: got %b expected 1", busy_at1); end
    checks++; if (first_wr != 12) begin errors++; $display("FAIL first_wr_cycle: got %0d expected 12", first_wr); end
    checks++; if (first_wr_addr !== 9'h100) begin errors++; $display("FAIL first_wr_addr: got %h expected 100", first_wr_addr); end
    checks++; if (done_cyc != 321) begin errors++; $display("FAIL done_cycle: got %0d expected 321", done_cyc); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL done_count: got %0d expected 1", done_cnt); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b expected 0", busy_at_done); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL rd_wr_overlap: got %0d expected 0", overlap); end
    checks++; if (parity_after !== 1'b1) begin errors++; $display("FAIL parity_step1: got %b expected 1", parity_after); end
  endtask

  task automatic test_pull();
    checks++; if (mem[addr_of(1, 1, 0, 0)] !== 16'd19) begin errors++; $display("FAIL pull_d1_00: got %0d expected 19", mem[addr_of(1, 1, 0, 0)]); end
    checks++; if (mem[addr_of(1, 6, 0, 0)] !== 16'd111) begin errors++; $display("FAIL pull_d6_00: got %0d expected 111", mem[addr_of(1, 6, 0, 0)]); end
    checks++; if (mem[addr_of(1, 8, 3, 3)] !== 16'd136) begin errors++; $display("FAIL pull_d8_33: got %0d expected 136", mem[addr_of(1, 8, 3, 3)]); end
    checks++; if (mem[addr_of(1, 5, 3, 3)] !== 16'd80) begin errors++; $display("FAIL pull_d5_33: got %0d expected 80", mem[addr_of(1, 5, 3, 3)]); end
    for (int d = 0; d < 9; d++)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++) begin
          checks++;
          if (mem[addr_of(1, d, x, y)] !== exp_val(d, x, y, 1)) begin
            errors++;
            $display("FAIL pull_sweep d=%0d x=%0d y=%0d: got %0d expected %0d", d, x, y, mem[addr_of(1, d, x, y)], exp_val(d, x, y, 1));
          end
        end
  endtask

  task automatic test_back_to_back();
    run_step(0, 0);
    checks++; if (first_rd_addr !== 9'h100) begin errors++; $display("FAIL b2b_rd_buf: got %h expected 100", first_rd_addr); end
    checks++; if (first_wr_addr !== 9'h000) begin errors++; $display("FAIL b2b_wr_buf: got %h expected 000", first_wr_addr); end
    checks++; if (done_cyc != 321) begin errors++; $display("FAIL b2b_done_cycle: got %0d expected 321", done_cyc); end
    checks++; if (parity_after !== 1'b0) begin errors++; $display("FAIL b2b_parity: got %b expected 0", parity_after); end
    for (int d = 0; d < 9; d++)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++) begin
          checks++;
          if (mem[addr_of(0, d, x, y)] !== exp_val(d, x, y, 2)) begin
            errors++;
            $display("FAIL b2b_sweep d=%0d x=%0d y=%0d: got %0d expected %0d", d, x, y, mem[addr_of(0, d, x, y)], exp_val(d, x, y, 2));
          end
        end
  endtask

  task automatic test_busy_start();
    bit rebusy;
    run_step(50, 200);
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_start_done_count: got %0d expected 1", done_cnt); end
    checks++; if (done_cyc != 321) begin errors++; $display("FAIL busy_start_done_cycle: got %0d expected 321", done_cyc); end
    checks++; if (parity_after !== 1'b1) begin errors++; $display("FAIL busy_start_parity: got %b expected 1", parity_after); end
    rebusy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (busy) rebusy = 1'b1;
    end
    checks++; if (rebusy) begin errors++; $display("FAIL busy_start_retrigger: got busy after done expected idle"); end
  endtask

  task automatic test_vis();
    run_step(0, 0);
    checks++; if (vis_cnt != 16) begin errors++; $display("FAIL vis_count: got %0d expected 16", vis_cnt); end
    checks++; if (vis6_cnt != 1) begin errors++; $display("FAIL vis_cell6_count: got %0d expected 1", vis6_cnt); end
    checks++; if (vis6_data !== 16'h1234) begin errors++; $display("FAIL vis_cell6_data: got %h expected 1234", vis6_data); end
    checks++; if (vis_bad != 0) begin errors++; $display("FAIL vis_data_all: got %0d wrong values expected 0", vis_bad); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_abort();
    test_timing();
    test_pull();
    test_back_to_back();
    test_busy_start();
    test_vis();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
